// File: rtl/w0rm_alu_divrem_iter_if.sv
// rtl/w0rm_alu_divrem_iter_if.sv - operand/result handshake bundle for the iterative divide/remainder unit
interface w0rm_alu_divrem_iter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_valid;
    logic                  ready;
    logic [3:0]            opcode;
    logic                  is_signed;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic [DATA_WIDTH-1:0] result;
    logic                  result_valid;
    logic [3:0]            result_flags;
    logic                  div_zero;

    modport master (
        output data_valid, opcode, is_signed, data_a, data_b,
        input  ready, result, result_valid, result_flags, div_zero
    );

    modport slave (
        input  data_valid, opcode, is_signed, data_a, data_b,
        output ready, result, result_valid, result_flags, div_zero
    );
endinterface

// File: rtl/w0rm_alu_divrem_iter.sv
// rtl/w0rm_alu_divrem_iter.sv - fixed-latency restoring signed/unsigned DIV/REM, BITS_PER_CYCLE bits per step
module w0rm_alu_divrem_iter #(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    w0rm_alu_divrem_iter_if.slave     bus_io
);
    localparam int W  = DATA_WIDTH;
    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [3:0]   OP_DIV  = 4'h6;
    localparam logic [3:0]   OP_REM  = 4'h7;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    generate
        if (DATA_WIDTH < 2 || BITS_PER_CYCLE < 1 || (DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
            $fatal(1, "w0rm_alu_divrem_iter: DATA_WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP} state_t;

    state_t        state_q;
    logic [3:0]    op_q;
    logic          sgn_q;
    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  quo_q, dvs_q, rem_q;
    logic [CW-1:0] cnt_q;
    logic          q_neg_q, r_neg_q, dz_q, ovf_q;
    logic [W-1:0]  result_q;
    logic          div_zero_q, over_q, ready_q, result_valid_q;

    logic [W:0]    rem_v;
    logic [W-1:0]  quo_v;
    logic [W-1:0]  quo_d, rem_d;
    logic [W-1:0]  q_signed, r_signed, fix_res;
    logic          op_ok;

    // quo_q starts as the dividend magnitude and is shifted out MSB first while quotient bits shift in.
    always_comb begin
        rem_v = {1'b0, rem_q};
        quo_v = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_v = {rem_v[W-1:0], quo_v[W-1]};
            quo_v = {quo_v[W-2:0], 1'b0};
            if (rem_v >= {1'b0, dvs_q}) begin
                rem_v    = rem_v - {1'b0, dvs_q};
                quo_v[0] = 1'b1;
            end
        end
        quo_d = quo_v;
        rem_d = rem_v[W-1:0];
    end

    assign op_ok    = (op_q == OP_DIV) || (op_q == OP_REM);
    assign q_signed = q_neg_q ? -quo_q : quo_q;
    assign r_signed = r_neg_q ? -rem_q : rem_q;

    always_comb begin
        fix_res = '0;
        if (op_q == OP_DIV) begin
            fix_res = dz_q ? '1 : (ovf_q ? a_q : q_signed);
        end else if (op_q == OP_REM) begin
            fix_res = dz_q ? a_q : (ovf_q ? '0 : r_signed);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            sgn_q          <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            quo_q          <= '0;
            dvs_q          <= '0;
            rem_q          <= '0;
            cnt_q          <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            dz_q           <= 1'b0;
            ovf_q          <= 1'b0;
            result_q       <= '0;
            div_zero_q     <= 1'b0;
            over_q         <= 1'b0;
            ready_q        <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus_io.data_valid) begin
                        op_q    <= bus_io.opcode;
                        sgn_q   <= bus_io.is_signed;
                        a_q     <= bus_io.data_a;
                        b_q     <= bus_io.data_b;
                        ready_q <= 1'b0;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    // The most-negative value negates to itself, which is its correct unsigned magnitude.
                    quo_q   <= (sgn_q && a_q[W-1]) ? -a_q : a_q;
                    dvs_q   <= (sgn_q && b_q[W-1]) ? -b_q : b_q;
                    rem_q   <= '0;
                    cnt_q   <= CW'(N);
                    q_neg_q <= sgn_q && (a_q[W-1] ^ b_q[W-1]);
                    r_neg_q <= sgn_q && a_q[W-1];
                    dz_q    <= (b_q == '0);
                    ovf_q   <= sgn_q && (a_q == MIN_NEG) && (b_q == '1);
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    result_q       <= fix_res;
                    div_zero_q     <= dz_q;
                    over_q         <= ovf_q && op_ok;
                    result_valid_q <= 1'b1;
                    ready_q        <= 1'b1;
                    state_q        <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_io.ready        = ready_q;
    assign bus_io.result       = result_q;
    assign bus_io.result_valid = result_valid_q;
    assign bus_io.div_zero     = div_zero_q;
    assign bus_io.result_flags = {1'b0, over_q, result_q[W-1], (result_q == '0)};
endmodule

// File: tb/tb_w0rm_alu_divrem_iter.sv
// tb/tb_w0rm_alu_divrem_iter.sv - scoreboard bench for three width/radix configurations of the divider
module tb_w0rm_alu_divrem_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        logic        dz;
        int          cap;
    } sb_t;
    sb_t sbq0[$];
    sb_t sbq1[$];
    sb_t sbq2[$];

    logic [2:0]  v = 3'b000;
    logic [3:0]  op_drv = 4'h0;
    logic        s_drv = 1'b0;
    logic [31:0] a_drv = 32'd0;
    logic [31:0] b_drv = 32'd0;

    w0rm_alu_divrem_iter_if #(.DATA_WIDTH(8))  b8 ();
    w0rm_alu_divrem_iter_if #(.DATA_WIDTH(16)) b16 ();
    w0rm_alu_divrem_iter_if #(.DATA_WIDTH(32)) b32 ();

    assign b8.data_valid  = v[0];
    assign b8.opcode      = op_drv;
    assign b8.is_signed   = s_drv;
    assign b8.data_a      = a_drv[7:0];
    assign b8.data_b      = b_drv[7:0];
    assign b16.data_valid = v[1];
    assign b16.opcode     = op_drv;
    assign b16.is_signed  = s_drv;
    assign b16.data_a     = a_drv[15:0];
    assign b16.data_b     = b_drv[15:0];
    assign b32.data_valid = v[2];
    assign b32.opcode     = op_drv;
    assign b32.is_signed  = s_drv;
    assign b32.data_a     = a_drv;
    assign b32.data_b     = b_drv;

    w0rm_alu_divrem_iter #(.DATA_WIDTH(8),  .BITS_PER_CYCLE(1)) u8  (.clk_i(clk), .rst_i(rst), .bus_io(b8));
    w0rm_alu_divrem_iter #(.DATA_WIDTH(16), .BITS_PER_CYCLE(2)) u16 (.clk_i(clk), .rst_i(rst), .bus_io(b16));
    w0rm_alu_divrem_iter #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u32 (.clk_i(clk), .rst_i(rst), .bus_io(b32));

    logic [31:0] res_w [3];
    logic [3:0]  fl_w  [3];
    logic        rv_w  [3];
    logic        rdy_w [3];
    logic        dz_w  [3];
    assign res_w[0] = {24'd0, b8.result};
    assign res_w[1] = {16'd0, b16.result};
    assign res_w[2] = b32.result;
    assign fl_w[0]  = b8.result_flags;
    assign fl_w[1]  = b16.result_flags;
    assign fl_w[2]  = b32.result_flags;
    assign rv_w[0]  = b8.result_valid;
    assign rv_w[1]  = b16.result_valid;
    assign rv_w[2]  = b32.result_valid;
    assign rdy_w[0] = b8.ready;
    assign rdy_w[1] = b16.ready;
    assign rdy_w[2] = b32.ready;
    assign dz_w[0]  = b8.div_zero;
    assign dz_w[1]  = b16.div_zero;
    assign dz_w[2]  = b32.div_zero;

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 16 : 32);
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    // Reference model in 64-bit signed arithmetic: '/' truncates toward zero, '%' follows the dividend sign.
    function automatic sb_t model(input int w, input logic [3:0] op, input logic s,
                                  input logic [31:0] a_in, input logic [31:0] b_in);
        sb_t         r;
        logic [31:0] msk, a, b, res;
        longint      sa, sbv, qv, rv;
        logic        ov;
        msk = mask_of(w);
        a   = a_in & msk;
        b   = b_in & msk;
        sa  = (s && a[w-1]) ? (longint'(a) - (64'sd1 <<< w)) : longint'(a);
        sbv = (s && b[w-1]) ? (longint'(b) - (64'sd1 <<< w)) : longint'(b);
        ov  = 1'b0;
        if (b == 32'd0) begin
            qv = longint'(msk);
            rv = sa;
        end else if (s && a == (32'd1 << (w - 1)) && b == msk) begin
            qv = longint'(a);
            rv = 0;
            ov = 1'b1;
        end else begin
            qv = sa / sbv;
            rv = sa % sbv;
        end
        if (op == 4'h6) res = qv[31:0];
        else if (op == 4'h7) res = rv[31:0];
        else begin
            res = 32'd0;
            ov  = 1'b0;
        end
        res   = res & msk;
        r.res = res;
        r.fl  = {1'b0, ov, res[w-1], (res == 32'd0)};
        r.dz  = (b == 32'd0);
        r.cap = 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, o, e);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? sbq0.size() : ((k == 1) ? sbq1.size() : sbq2.size());
    endfunction

    function automatic sb_t qpop(input int k);
        if (k == 0) return sbq0.pop_front();
        else if (k == 1) return sbq1.pop_front();
        else return sbq2.pop_front();
    endfunction

    task automatic qpush(input int k, input sb_t e);
        if (k == 0) sbq0.push_back(e);
        else if (k == 1) sbq1.push_back(e);
        else sbq2.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rv_w[k] === 1'b1) begin
                sb_t e;
                int  n;
                n = qsize(k);
                chk($sformatf("unexpected_valid%0d", k), {31'd0, (n != 0)}, 32'd1);
                if (n != 0) begin
                    e = qpop(k);
                    chk($sformatf("result%0d", k), res_w[k], e.res);
                    chk($sformatf("flags%0d", k), {28'd0, fl_w[k]}, {28'd0, e.fl});
                    chk($sformatf("div_zero%0d", k), {31'd0, dz_w[k]}, {31'd0, e.dz});
                    chk($sformatf("latency%0d", k), 32'(cyc - e.cap), 32'd10);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic [3:0] op, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
        int  guard;
        sb_t e;
        guard = 0;
        while (rdy_w[k] !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        chk($sformatf("ready_wait%0d", k), {31'd0, rdy_w[k]}, 32'd1);
        op_drv = op;
        s_drv  = s;
        a_drv  = a;
        b_drv  = b;
        v[k]   = 1'b1;
        e      = model(width_of(k), op, s, a, b);
        e.cap  = cyc + 1;
        qpush(k, e);
        tick();
        v[k] = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while ((sbq0.size() + sbq1.size() + sbq2.size()) != 0 && guard < 60) begin
            tick();
            guard++;
        end
        chk("drain", 32'(sbq0.size() + sbq1.size() + sbq2.size()), 32'd0);
        tick();
    endtask

    initial begin
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), {31'd0, rdy_w[k]}, 32'd1);
            chk($sformatf("rst_result%0d", k), res_w[k], 32'd0);
            chk($sformatf("rst_flags%0d", k), {28'd0, fl_w[k]}, 32'd1);
            chk($sformatf("rst_valid%0d", k), {31'd0, rv_w[k]}, 32'd0);
            chk($sformatf("rst_dz%0d", k), {31'd0, dz_w[k]}, 32'd0);
        end
        rst = 1'b0;
        tick();

        drv(0, 4'h6, 1'b0, 32'd200, 32'd7);  wait_done();
        drv(0, 4'h7, 1'b0, 32'd200, 32'd7);  wait_done();
        drv(0, 4'h6, 1'b1, 32'hF9, 32'h02);  wait_done();
        drv(0, 4'h7, 1'b1, 32'hF9, 32'h02);  wait_done();
        drv(0, 4'h6, 1'b1, 32'h07, 32'hFE);  wait_done();
        drv(0, 4'h7, 1'b1, 32'h07, 32'hFE);  wait_done();
        drv(0, 4'h6, 1'b1, 32'h80, 32'hFF);  wait_done();
        drv(0, 4'h7, 1'b1, 32'h80, 32'hFF);  wait_done();
        drv(0, 4'h6, 1'b1, 32'h80, 32'h01);  wait_done();
        drv(0, 4'h3, 1'b0, 32'h55, 32'h00);  wait_done();
        drv(0, 4'h7, 1'b0, 32'h2A, 32'h00);  wait_done();
        drv(0, 4'h6, 1'b0, 32'h2A, 32'h00);  wait_done();

        // Asynchronous reset mid-operation discards the operation and clears the held divide-by-zero result.
        drv(0, 4'h6, 1'b0, 32'd100, 32'd3);
        repeat (3) tick();
        #3;
        rst = 1'b1;
        sbq0.delete();
        #1;
        chk("midrst_ready", {31'd0, rdy_w[0]}, 32'd1);
        chk("midrst_result", res_w[0], 32'd0);
        chk("midrst_flags", {28'd0, fl_w[0]}, 32'd1);
        chk("midrst_dz", {31'd0, dz_w[0]}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (14) tick();
        chk("post_rst_result", res_w[0], 32'd0);
        drv(0, 4'h6, 1'b0, 32'd250, 32'd10); wait_done();

        // Busy-time strobes must be ignored; a strobe in the result_valid cycle must be taken.
        drv(0, 4'h6, 1'b0, 32'd99, 32'd9);
        for (int i = 1; i <= 9; i++) begin
            op_drv = 4'h7;
            a_drv  = 32'($urandom_range(0, 255));
            b_drv  = 32'($urandom_range(1, 255));
            v[0]   = 1'b1;
            tick();
        end
        v[0] = 1'b0;
        tick();
        chk("b2b_in_valid_cycle", {31'd0, rv_w[0]}, 32'd1);
        drv(0, 4'h7, 1'b1, 32'h9C, 32'h05);
        wait_done();

        for (int k = 1; k < 3; k++) begin
            int w;
            w = width_of(k);
            drv(k, 4'h6, 1'b1, 32'd1 << (w - 1), mask_of(w)); wait_done();
            drv(k, 4'h7, 1'b1, 32'd1 << (w - 1), mask_of(w)); wait_done();
            drv(k, 4'h6, 1'b1, 32'h1234_5678, 32'd0);        wait_done();
            drv(k, 4'h7, 1'b0, 32'h8765_4321, 32'd0);        wait_done();
        end
        for (int i = 0; i < 24; i++) begin
            for (int k = 1; k < 3; k++) begin
                int          w;
                logic [31:0] a, b;
                logic [3:0]  op;
                w  = width_of(k);
                a  = $urandom;
                b  = ($urandom & mask_of(w)) >> $urandom_range(0, w - 1);
                op = ($urandom_range(0, 7) == 0) ? 4'hA : (($urandom_range(0, 1) == 0) ? 4'h6 : 4'h7);
                drv(k, op, 1'($urandom_range(0, 1)), a, b);
                wait_done();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/w0rm_alu_divrem_iter.md
Name: w0rm_alu_divrem_iter

Overview:
- Parametrised, fixed-latency iterative signed/unsigned divide/remainder unit for the W0RM ALU.
- Next generation of the single-width DIV/REM unit. Replaces the external divider core and static delay timer with an internal restoring-division FSM.
- Adds a ready/valid handshake, a configurable radix (bits retired per cycle), a signed/unsigned mode, and defined divide-by-zero and signed-overflow results.
- Sits in the ALU execute stage beside the add/logic/shift units and shares their opcode and flag conventions.

Parameters:
- DATA_WIDTH, 8, operand and result width. Must be 2 or more.
- BITS_PER_CYCLE, 1, quotient bits retired per ITER cycle. DATA_WIDTH must be an integer multiple of it; otherwise elaboration fails.
- Derived N = DATA_WIDTH / BITS_PER_CYCLE, the ITER cycle count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- data_valid  in  1  operand strobe; sampled only while ready=1
- ready  out  1  high in IDLE; unit will accept data_valid this cycle
- opcode  in  4  4'h6 = DIV, 4'h7 = REM; any other value is invalid
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned
- data_a  in  DATA_WIDTH  dividend
- data_b  in  DATA_WIDTH  divisor
- result  out  DATA_WIDTH  quotient or remainder; held until the next completion
- result_valid  out  1  one-cycle pulse when result and flags update
- result_flags  out  4  bit0 zero, bit1 neg, bit2 over, bit3 carry (always 0)
- div_zero  out  1  divisor was zero for the current result; held with result

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - FSM goes to IDLE; ready=1, result_valid=0.
  - result, div_zero and all internal registers clear to 0; result_flags therefore reads 4'b0001.
  - Any operation in flight is discarded and produces no result_valid.
- FSM states:
  - IDLE: ready=1. data_valid=1 captures opcode, is_signed, data_a and data_b, then moves to PREP. data_valid while ready=0 is ignored.
  - PREP, 1 cycle: forms operand magnitudes (absolute values when is_signed=1), records the quotient and remainder signs and the special cases, clears the partial remainder and loads the iteration counter with N.
  - ITER, N cycles: each cycle runs BITS_PER_CYCLE restoring shift/compare/subtract steps, MSB first. Counter reaches 0, then moves to FIXUP.
  - FIXUP, 1 cycle: sign correction and special-case override. Loads result and div_zero and pulses result_valid, then returns to IDLE.
- Latency is fixed and independent of operand values or special cases:
  - Capture on edge E0; result, result_valid and div_zero update on edge E0+N+2; ready returns high on that same edge.
  - DATA_WIDTH=8, BITS_PER_CYCLE=1 gives 10 cycles. BITS_PER_CYCLE=2 gives 6 cycles.
- Back-to-back: a new operand set may be captured in the cycle result_valid is high. Throughput is one operation per N+2 cycles.
- Arithmetic:
  - Division truncates toward zero.
  - Remainder takes the sign of the dividend, and dividend = quotient*divisor + remainder holds.
  - Quotient is negative when the operand signs differ (signed mode only).
- Divide by zero (data_b=0, either mode): quotient = all ones, remainder = data_a, div_zero=1, over=0.
- Signed overflow (is_signed=1, data_a = most-negative value, data_b = all ones): quotient = data_a, remainder = 0, over=1. This is the only case that sets over.
- Invalid opcode: full latency, result=0, div_zero is computed normally, flags are derived from result=0.
- Flags are combinational from the registered result and registered special-case state:
  - zero = (result == 0)
  - neg = result MSB
  - over as defined above; carry = 0.
- result, result_flags and div_zero hold their values between completions.

Test Plan:
- Unsigned DIV, 8-bit radix-1: a=200, b=7, is_signed=0 -> result_valid exactly 10 cycles after capture, result=0x1C, flags=0000, div_zero=0. Repeat as REM -> result=0x04.
- Signed DIV/REM: a=0xF9 (-7), b=0x02 -> DIV result=0xFD, flags=0010; REM result=0xFF, flags=0010. a=0x07, b=0xFE -> DIV 0xFD, REM 0x01.
- Special cases: a=0x2A, b=0 -> DIV 0xFF with div_zero=1, REM 0x2A. Signed a=0x80, b=0xFF -> DIV 0x80 with over=1 and neg=1, REM 0x00 with zero=1. Latency is 10 cycles in every case.
- Handshake: pulse data_valid in cycles 1-9 after capture with different operands -> ignored and the first result is unchanged. Apply a new data_valid in the result_valid cycle -> captured, second result 10 cycles later.
- Reset mid-operation: assert reset asynchronously 4 cycles after capture -> ready=1, result=0, flags=0001 immediately. No result_valid pulse follows. The next operation completes normally.
- Parameter sweep: DATA_WIDTH=16/BITS_PER_CYCLE=2 and DATA_WIDTH=32/BITS_PER_CYCLE=4, random signed/unsigned operands against a reference model -> latency N+2 (10 cycles in both cases), all results and flags match.
